// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x fractional-baud oversampling, majority-vote bit sampling,
// optional parity, 1/2 stop bits and a receive FIFO with sticky error flags.
module uart_rx_fifo #(
  parameter int SYSCLK_FREQ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rx,
  input  logic                          rd_comp,
  input  logic                          err_clr,
  output logic [7:0]                    rd_data,
  output logic                          rd_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned ACC_W = $clog2(SYSCLK_FREQ + 16 * BAUD_RATE) + 1;
  localparam logic [ACC_W-1:0] ACC_INC = ACC_W'(16 * BAUD_RATE);
  localparam logic [ACC_W-1:0] ACC_MOD = ACC_W'(SYSCLK_FREQ);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic                 sync1, sync2, rx_d;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic                 tick, mid, last;
  logic [3:0]           tick_cnt;
  logic                 s7, s8, maj;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 push, set_frame, set_parity;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 full, pop, wr_ok;

  always_comb begin
    acc_sum = acc + ACC_INC;
    tick    = (state != S_IDLE) && (acc_sum >= ACC_MOD);
    mid     = tick && (tick_cnt == 4'd9);
    last    = tick && (tick_cnt == 4'd15);
    maj     = (s7 & s8) | (s7 & sync2) | (s8 & sync2);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
    case (state)
      S_IDLE:   if (rx_d && !sync2) state_nxt = S_START;
      S_START: begin
        if (mid && maj)  state_nxt = S_IDLE;
        else if (last)   state_nxt = S_DATA;
      end
      S_DATA:   if (last && bit_cnt == LAST_DATA)
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (last) state_nxt = S_STOP;
      S_STOP: begin
        // Leave at the mid-sample so the next start edge is caught without delay.
        if (mid) begin
          if (!maj) begin
            state_nxt  = S_IDLE;
            set_frame  = 1'b1;
            set_parity = par_bad;
          end else if (bit_cnt == LAST_STOP) begin
            state_nxt  = S_IDLE;
            set_parity = par_bad;
            push       = !par_bad;
          end
        end
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_d     <= 1'b1;
      acc      <= '0;
      tick_cnt <= '0;
      s7       <= 1'b0;
      s8       <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bad  <= 1'b0;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
      rx_d  <= sync2;
      if (state == S_IDLE) begin
        acc      <= '0;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        par_bad  <= 1'b0;
      end else begin
        if (tick) begin
          acc      <= acc_sum - ACC_MOD;
          tick_cnt <= tick_cnt + 4'd1;
        end else begin
          acc <= acc_sum;
        end
        if (tick && tick_cnt == 4'd7) s7 <= sync2;
        if (tick && tick_cnt == 4'd8) s8 <= sync2;
        if (mid && state == S_DATA)   shreg <= {maj, shreg[DATA_BITS-1:1]};
        if (mid && state == S_PARITY) par_bad <= (maj != ((^shreg) ^ PAR_ODD));
        if (last) bit_cnt <= (state_nxt != state) ? 3'd0 : bit_cnt + 3'd1;
      end
    end
  end

  assign full  = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign rd_en = (fifo_count != '0);
  assign pop   = rd_comp && rd_en;
  assign wr_ok = push && !full;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (set_frame)        frame_err  <= 1'b1;
      else if (err_clr)     frame_err  <= 1'b0;
      if (set_parity)       parity_err <= 1'b1;
      else if (err_clr)     parity_err <= 1'b0;
      if (push && full)     overrun    <= 1'b1;
      else if (err_clr)     overrun    <= 1'b0;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_en) rd_data[DATA_BITS-1:0] = mem[rd_ptr];
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: four receivers (8N1, 8E1, 8N2, 7N1), 16 clk per bit.
module tb_uart_rx_fifo;

  logic       clk, rst;
  logic       rx  [4];
  logic       rdc [4];
  logic       ecl [4];
  logic [7:0] rdd [4];
  logic       rde [4];
  logic [2:0] cnt [4];
  logic       fe  [4];
  logic       pe  [4];
  logic       ov  [4];

  int n_cmp, n_bad;

  uart_rx_fifo #(.SYSCLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .uart_rx(rx[0]), .rd_comp(rdc[0]), .err_clr(ecl[0]),
    .rd_data(rdd[0]), .rd_en(rde[0]), .fifo_count(cnt[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));

  uart_rx_fifo #(.SYSCLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .uart_rx(rx[1]), .rd_comp(rdc[1]), .err_clr(ecl[1]),
    .rd_data(rdd[1]), .rd_en(rde[1]), .fifo_count(cnt[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));

  uart_rx_fifo #(.SYSCLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(4)) u_8n2 (
    .clk(clk), .rst(rst), .uart_rx(rx[2]), .rd_comp(rdc[2]), .err_clr(ecl[2]),
    .rd_data(rdd[2]), .rd_en(rde[2]), .fifo_count(cnt[2]),
    .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]));

  uart_rx_fifo #(.SYSCLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(4)) u_7n1 (
    .clk(clk), .rst(rst), .uart_rx(rx[3]), .rd_comp(rdc[3]), .err_clr(ecl[3]),
    .rd_data(rdd[3]), .rd_en(rde[3]), .fifo_count(cnt[3]),
    .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ov[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One frame, 16 negedges per bit; optional pop strobe and rd_en probes at frame-relative negedges.
  task automatic send_frame(input int i, input logic [7:0] d, input int nbits, input int par,
                            input int nstop, input logic last_stop, input int pop_at,
                            input int probe, output logic pre, output logic post);
    logic q[$];
    int n;
    n = 0;
    pre = 1'bx;
    post = 1'bx;
    q.push_back(1'b0);
    for (int k = 0; k < nbits; k++) q.push_back(d[k]);
    if (par >= 0) q.push_back(par[0]);
    for (int s = 0; s < nstop; s++) q.push_back((s == nstop - 1) ? last_stop : 1'b1);
    foreach (q[b]) begin
      rx[i] = q[b];
      for (int c = 0; c < 16; c++) begin
        if (pop_at >= 0) rdc[i] = (n == pop_at);
        if (n == probe) pre = rde[i];
        if (n == probe + 1) post = rde[i];
        @(negedge clk);
        n++;
      end
    end
    rx[i] = 1'b1;
    if (pop_at >= 0) rdc[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [7:0] d, input int nbits, input int par,
                      input int nstop, input logic last_stop);
    logic a, b;
    send_frame(i, d, nbits, par, nstop, last_stop, -1, -10, a, b);
  endtask

  task automatic pop(input int i);
    rdc[i] = 1'b1;
    @(negedge clk);
    rdc[i] = 1'b0;
  endtask

  task automatic clr(input int i);
    ecl[i] = 1'b1;
    @(negedge clk);
    ecl[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rde[i] !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en[%0d] got %b want 0", i, rde[i]); end
      n_cmp++; if (rdd[i] !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data[%0d] got %h want 00", i, rdd[i]); end
      n_cmp++; if (cnt[i] !== 3'd0) begin n_bad++; $display("FAIL reset_count[%0d] got %0d want 0", i, cnt[i]); end
      n_cmp++; if (fe[i] !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err[%0d] got %b want 0", i, fe[i]); end
      n_cmp++; if (pe[i] !== 1'b0) begin n_bad++; $display("FAIL reset_parity_err[%0d] got %b want 0", i, pe[i]); end
      n_cmp++; if (ov[i] !== 1'b0) begin n_bad++; $display("FAIL reset_overrun[%0d] got %b want 0", i, ov[i]); end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    logic pre, post;
    // Stop-bit mid-sample lands on posedge 157 of the frame: rd_en low at negedge 156, high at 157.
    send_frame(0, 8'hA5, 8, -1, 1, 1'b1, -1, 156, pre, post);
    n_cmp++; if (pre !== 1'b0) begin n_bad++; $display("FAIL basic_pre_push_rd_en got %b want 0", pre); end
    n_cmp++; if (post !== 1'b1) begin n_bad++; $display("FAIL basic_push_latency_rd_en got %b want 1", post); end
    n_cmp++; if (rdd[0] !== 8'hA5) begin n_bad++; $display("FAIL basic_rd_data got %h want a5", rdd[0]); end
    n_cmp++; if (cnt[0] !== 3'd1) begin n_bad++; $display("FAIL basic_count got %0d want 1", cnt[0]); end
    n_cmp++; if (fe[0] !== 1'b0) begin n_bad++; $display("FAIL basic_frame_err got %b want 0", fe[0]); end
    pop(0);
    n_cmp++; if (rde[0] !== 1'b0) begin n_bad++; $display("FAIL basic_pop_rd_en got %b want 0", rde[0]); end
    n_cmp++; if (rdd[0] !== 8'h00) begin n_bad++; $display("FAIL basic_empty_rd_data got %h want 00", rdd[0]); end
    pop(0);
    n_cmp++; if (cnt[0] !== 3'd0) begin n_bad++; $display("FAIL empty_pop_count got %0d want 0", cnt[0]); end
  endtask

  task automatic test_parity();
    send(1, 8'h03, 8, 1, 1, 1'b1);
    n_cmp++; if (pe[1] !== 1'b1) begin n_bad++; $display("FAIL parity_err_set got %b want 1", pe[1]); end
    n_cmp++; if (cnt[1] !== 3'd0) begin n_bad++; $display("FAIL parity_no_push got %0d want 0", cnt[1]); end
    n_cmp++; if (fe[1] !== 1'b0) begin n_bad++; $display("FAIL parity_frame_err got %b want 0", fe[1]); end
    clr(1);
    n_cmp++; if (pe[1] !== 1'b0) begin n_bad++; $display("FAIL parity_err_clr got %b want 0", pe[1]); end
    send(1, 8'h03, 8, 0, 1, 1'b1);
    n_cmp++; if (cnt[1] !== 3'd1) begin n_bad++; $display("FAIL parity_good_count got %0d want 1", cnt[1]); end
    n_cmp++; if (rdd[1] !== 8'h03) begin n_bad++; $display("FAIL parity_good_data got %h want 03", rdd[1]); end
    n_cmp++; if (pe[1] !== 1'b0) begin n_bad++; $display("FAIL parity_good_err got %b want 0", pe[1]); end
    send(1, 8'h07, 8, 1, 1, 1'b1);
    n_cmp++; if (rdd[1] !== 8'h03 || cnt[1] !== 3'd2) begin
      n_bad++; $display("FAIL parity_odd_ones_push got %h/%0d want 03/2", rdd[1], cnt[1]);
    end
    pop(1);
    pop(1);
  endtask

  task automatic test_frame_err();
    send(2, 8'hC3, 8, -1, 2, 1'b0);
    n_cmp++; if (fe[2] !== 1'b1) begin n_bad++; $display("FAIL frame_err_set got %b want 1", fe[2]); end
    n_cmp++; if (cnt[2] !== 3'd0) begin n_bad++; $display("FAIL frame_no_push got %0d want 0", cnt[2]); end
    repeat (16) @(negedge clk);
    send(2, 8'h5A, 8, -1, 2, 1'b1);
    n_cmp++; if (cnt[2] !== 3'd1) begin n_bad++; $display("FAIL frame_next_count got %0d want 1", cnt[2]); end
    n_cmp++; if (rdd[2] !== 8'h5A) begin n_bad++; $display("FAIL frame_next_data got %h want 5a", rdd[2]); end
    n_cmp++; if (fe[2] !== 1'b1) begin n_bad++; $display("FAIL frame_err_sticky got %b want 1", fe[2]); end
    clr(2);
    n_cmp++; if (fe[2] !== 1'b0) begin n_bad++; $display("FAIL frame_err_clr got %b want 0", fe[2]); end
    pop(2);
  endtask

  task automatic test_overrun();
    for (int b = 1; b <= 5; b++) send(0, 8'(b), 8, -1, 1, 1'b1);
    n_cmp++; if (cnt[0] !== 3'd4) begin n_bad++; $display("FAIL overrun_count got %0d want 4", cnt[0]); end
    n_cmp++; if (ov[0] !== 1'b1) begin n_bad++; $display("FAIL overrun_flag got %b want 1", ov[0]); end
    for (int b = 1; b <= 4; b++) begin
      n_cmp++; if (rdd[0] !== 8'(b)) begin n_bad++; $display("FAIL overrun_pop%0d got %h want %h", b, rdd[0], 8'(b)); end
      pop(0);
    end
    n_cmp++; if (rde[0] !== 1'b0) begin n_bad++; $display("FAIL overrun_drained got %b want 0", rde[0]); end
    clr(0);
    n_cmp++; if (ov[0] !== 1'b0) begin n_bad++; $display("FAIL overrun_clr got %b want 0", ov[0]); end
  endtask

  task automatic test_glitch_7n1();
    rx[3] = 1'b0;
    repeat (6) @(negedge clk);
    rx[3] = 1'b1;
    repeat (40) @(negedge clk);
    n_cmp++; if (cnt[3] !== 3'd0) begin n_bad++; $display("FAIL glitch_count got %0d want 0", cnt[3]); end
    n_cmp++; if (fe[3] !== 1'b0 || pe[3] !== 1'b0) begin
      n_bad++; $display("FAIL glitch_errors got fe=%b pe=%b want 0 0", fe[3], pe[3]);
    end
    send(3, 8'h7F, 7, -1, 1, 1'b1);
    n_cmp++; if (rdd[3] !== 8'h7F) begin n_bad++; $display("FAIL 7n1_data got %h want 7f", rdd[3]); end
    n_cmp++; if (cnt[3] !== 3'd1) begin n_bad++; $display("FAIL 7n1_count got %0d want 1", cnt[3]); end
    pop(3);
    send(3, 8'h2A, 7, -1, 1, 1'b1);
    n_cmp++; if (rdd[3] !== 8'h2A) begin n_bad++; $display("FAIL 7n1_data2 got %h want 2a", rdd[3]); end
    pop(3);
  endtask

  task automatic test_back_to_back();
    logic a, b;
    send(0, 8'h11, 8, -1, 1, 1'b1);
    send(0, 8'h22, 8, -1, 1, 1'b1);
    n_cmp++; if (cnt[0] !== 3'd2) begin n_bad++; $display("FAIL b2b_setup_count got %0d want 2", cnt[0]); end
    send_frame(0, 8'h33, 8, -1, 1, 1'b1, 156, -10, a, b);
    n_cmp++; if (cnt[0] !== 3'd2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", cnt[0]); end
    n_cmp++; if (rdd[0] !== 8'h22) begin n_bad++; $display("FAIL b2b_head got %h want 22", rdd[0]); end
    pop(0);
    n_cmp++; if (rdd[0] !== 8'h33) begin n_bad++; $display("FAIL b2b_second got %h want 33", rdd[0]); end
    pop(0);
    n_cmp++; if (rde[0] !== 1'b0) begin n_bad++; $display("FAIL b2b_drained got %b want 0", rde[0]); end
  endtask

  task automatic test_reset_midframe();
    rx[0] = 1'b0;
    repeat (16) @(negedge clk);
    rx[0] = 1'b1;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_cmp++; if (cnt[0] !== 3'd0) begin n_bad++; $display("FAIL midrst_no_push got %0d want 0", cnt[0]); end
    n_cmp++; if (fe[0] !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_err got %b want 0", fe[0]); end
    send(0, 8'h3C, 8, -1, 1, 1'b1);
    n_cmp++; if (rdd[0] !== 8'h3C) begin n_bad++; $display("FAIL midrst_resume_data got %h want 3c", rdd[0]); end
    n_cmp++; if (cnt[0] !== 3'd1) begin n_bad++; $display("FAIL midrst_resume_count got %0d want 1", cnt[0]); end
    pop(0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx[i]  = 1'b1;
      rdc[i] = 1'b0;
      ecl[i] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_overrun();
    test_glitch_7n1();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
